// File: rtl/rvj1_soc_pkg.sv
// rvj1_soc_pkg: bus FSM encoding, arbitration modes and the default SoC memory map
package rvj1_soc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR} wb_state_e;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam logic [31:0] IRAM_BASE = 32'h3000_0000;
    localparam logic [31:0] DRAM_BASE = 32'h3000_4000;
    localparam logic [31:0] UART_BASE = 32'h3000_8000;
    localparam logic [31:0] MAP_MASK  = 32'hFFFF_C000;
    localparam logic [95:0] DEFAULT_BASE = {UART_BASE, DRAM_BASE, IRAM_BASE};
    localparam logic [95:0] DEFAULT_MASK = {3{MAP_MASK}};
endpackage

// File: rtl/rvj1_wb_arbiter.sv
// rvj1_wb_arbiter: two-request grant, fixed priority or round robin with last-grant state
module rvj1_wb_arbiter
    import rvj1_soc_pkg::*;
#(
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    logic last_q;
    // last_q = 1 means m1 won the previous arbitration, so m0 takes the next tie
    assign gnt_o = (ARB_MODE == ARB_RR && &req_i) ? (last_q ? 2'b01 : 2'b10)
                                                  : (req_i[0] ? 2'b01 : req_i);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) last_q <= 1'b1;
        else if (en_i && |req_i) last_q <= gnt_o[1];
endmodule

// File: rtl/rvj1_wb_intercon.sv
// rvj1_wb_intercon: two-master Wishbone interconnect with address decode, error and watchdog
module rvj1_wb_intercon
    import rvj1_soc_pkg::*;
#(
    parameter int                    NSLAVES        = 3,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE     = DEFAULT_BASE,
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK     = DEFAULT_MASK,
    parameter int                    ARB_MODE       = ARB_FIXED,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rstn_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [3:0]              m0_sel_i,
    input  logic [31:0]             m0_adr_i,
    input  logic [31:0]             m0_dat_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [31:0]             m0_dat_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [3:0]              m1_sel_i,
    input  logic [31:0]             m1_adr_i,
    input  logic [31:0]             m1_dat_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [31:0]             m1_dat_o,
    output logic [NSLAVES-1:0]      s_cyc_o,
    output logic [NSLAVES-1:0]      s_stb_o,
    output logic                    s_we_o,
    output logic [3:0]              s_sel_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    input  logic [NSLAVES-1:0]      s_ack_i,
    input  logic [NSLAVES*32-1:0]   s_dat_i
);
    wb_state_e          state_q;
    logic [1:0]         gnt_q, gnt, req;
    logic [NSLAVES-1:0] sel_q, dec;
    logic [15:0]        cnt_q;
    logic               active, g1, m_cyc, m_stb, ack_raw, ack, tmo, cyc_on, err;
    logic [31:0]        rdat;

    // one-hot of the lowest-indexed matching slave, zero on a miss
    function automatic logic [NSLAVES-1:0] decode(input logic [31:0] adr);
        decode = '0;
        for (int i = NSLAVES - 1; i >= 0; i--)
            if ((adr & SLAVE_MASK[i*32 +: 32]) == (SLAVE_BASE[i*32 +: 32] & SLAVE_MASK[i*32 +: 32]))
                decode = NSLAVES'(1) << i;
    endfunction

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    rvj1_wb_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk_i (wb_clk_i),
        .rst_ni(wb_rstn_i),
        .req_i (req),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (gnt)
    );
    assign dec     = decode(gnt[1] ? m1_adr_i : m0_adr_i);
    assign active  = state_q == ST_ACTIVE;
    assign g1      = gnt_q[1];
    assign m_cyc   = g1 ? m1_cyc_i : m0_cyc_i;
    assign m_stb   = g1 ? m1_stb_i : m0_stb_i;
    assign ack_raw = |(s_ack_i & sel_q);
    assign ack     = active && m_cyc && ack_raw;
    // an ack arriving on the watchdog limit still wins
    assign tmo     = active && m_cyc && !ack_raw && cnt_q == 16'(TIMEOUT_CYCLES);
    assign cyc_on  = active && m_cyc && !tmo;
    assign err     = state_q == ST_ERR || tmo;
    assign s_cyc_o = cyc_on ? sel_q : '0;
    assign s_stb_o = (cyc_on && m_stb) ? sel_q : '0;
    assign s_we_o  = active && (g1 ? m1_we_i : m0_we_i);
    assign s_sel_o = active ? (g1 ? m1_sel_i : m0_sel_i) : '0;
    assign s_adr_o = active ? (g1 ? m1_adr_i : m0_adr_i) : '0;
    assign s_dat_o = active ? (g1 ? m1_dat_i : m0_dat_i) : '0;
    always_comb begin
        rdat = '0;
        for (int i = 0; i < NSLAVES; i++) rdat |= sel_q[i] ? s_dat_i[i*32 +: 32] : '0;
    end
    assign m0_ack_o = ack && gnt_q[0];
    assign m1_ack_o = ack && gnt_q[1];
    assign m0_err_o = err && gnt_q[0];
    assign m1_err_o = err && gnt_q[1];
    assign m0_dat_o = (active && gnt_q[0]) ? rdat : '0;
    assign m1_dat_o = (active && gnt_q[1]) ? rdat : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
        if (!wb_rstn_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else case (state_q)
            ST_IDLE: if (|req) begin
                gnt_q   <= gnt;
                sel_q   <= dec;
                cnt_q   <= '0;
                state_q <= |dec ? ST_ACTIVE : ST_ERR;
            end
            ST_ACTIVE: begin
                cnt_q <= cnt_q + 16'd1;
                if (!m_cyc || ack || tmo) begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    sel_q   <= '0;
                end
            end
            default: begin
                state_q <= ST_IDLE;
                gnt_q   <= '0;
            end
        endcase
endmodule

// File: tb/tb_rvj1_wb_intercon.sv
// tb_rvj1_wb_intercon: directed checks of decode, arbitration, error, watchdog and reset
module tb_rvj1_wb_intercon;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [2:0]  s_ack;
    logic [95:0] s_dat;
    logic        r_m0_ack, r_m0_err, r_m1_ack, r_m1_err, r_s_we;
    logic [31:0] r_m0_dat, r_m1_dat, r_s_adr, r_s_dat;
    logic [2:0]  r_s_cyc, r_s_stb;
    logic [3:0]  r_s_sel;
    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_s_we;
    logic [31:0] f_m0_dat, f_m1_dat, f_s_adr, f_s_dat;
    logic [2:0]  f_s_cyc, f_s_stb;
    logic [3:0]  f_s_sel;
    int          n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    rvj1_wb_intercon #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err), .m0_dat_o(r_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err), .m1_dat_o(r_m1_dat),
        .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb), .s_we_o(r_s_we), .s_sel_o(r_s_sel),
        .s_adr_o(r_s_adr), .s_dat_o(r_s_dat), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    rvj1_wb_intercon #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut_fx (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err), .m0_dat_o(f_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err), .m1_dat_o(f_m1_dat),
        .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_we_o(f_s_we), .s_sel_o(f_s_sel),
        .s_adr_o(f_s_adr), .s_dat_o(f_s_dat), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int m, input logic on, input logic [31:0] adr);
        if (m == 0) begin
            m0_cyc = on; m0_stb = on; m0_adr = adr;
        end else begin
            m1_cyc = on; m1_stb = on; m1_adr = adr;
        end
    endtask

    initial begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = 0; m0_dat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = 0; m1_dat = 0;
        s_ack = 0;
        s_dat = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        repeat (2) tick();
        #1;
        chk("rst_s_cyc", r_s_cyc, 0);
        chk("rst_s_stb", r_s_stb, 0);
        chk("rst_m0_ack", r_m0_ack, 0);
        chk("rst_m1_err", r_m1_err, 0);
        chk("rst_s_sel", r_s_sel, 0);
        rstn = 1'b1;

        // m1 reads DRAM, slave 1 acks two cycles after its cyc rises
        tick(); req(1, 1, 32'h3000_4010); #1;
        chk("s1_idle_cyc", r_s_cyc, 0);
        tick(); #1;
        chk("s1_cyc", r_s_cyc, 3'b010);
        chk("s1_stb", r_s_stb, 3'b010);
        chk("s1_adr", r_s_adr, 32'h3000_4010);
        chk("s1_noack0", r_m1_ack, 0);
        tick(); #1;
        chk("s1_noack1", r_m1_ack, 0);
        tick(); s_ack = 3'b010; #1;
        chk("s1_ack", r_m1_ack, 1);
        chk("s1_dat", r_m1_dat, 32'hDEAD_BEEF);
        chk("s1_cyc_ack", r_s_cyc, 3'b010);
        chk("s1_m0_ack", r_m0_ack, 0);
        chk("s1_m0_dat", r_m0_dat, 0);
        tick(); req(1, 0, 0); s_ack = 0; #1;
        chk("s1_done_cyc", r_s_cyc, 0);
        chk("s1_done_ack", r_m1_ack, 0);

        // simultaneous requests: round robin alternates, fixed keeps m0
        for (int i = 0; i < 4; i++) begin
            tick(); req(0, 1, 32'h3000_0000); req(1, 1, 32'h3000_0000);
            tick(); s_ack = 3'b001; #1;
            chk($sformatf("s2_rr_m0_%0d", i), r_m0_ack, (i % 2 == 0));
            chk($sformatf("s2_rr_m1_%0d", i), r_m1_ack, (i % 2 == 1));
            chk($sformatf("s2_fx_m0_%0d", i), f_m0_ack, 1);
            chk($sformatf("s2_fx_m1_%0d", i), f_m1_ack, 0);
            tick(); req(0, 0, 0); req(1, 0, 0); s_ack = 0;
        end

        // unmapped address: one-cycle error, no slave cycle
        tick(); req(0, 1, 32'h2000_0000); #1;
        chk("s3_req_cyc", r_s_cyc, 0);
        chk("s3_req_err", r_m0_err, 0);
        tick(); #1;
        chk("s3_err", r_m0_err, 1);
        chk("s3_fx_err", f_m0_err, 1);
        chk("s3_err_cyc", r_s_cyc, 0);
        chk("s3_err_ack", r_m0_ack, 0);
        chk("s3_m1_err", r_m1_err, 0);
        tick(); req(0, 0, 0); #1;
        chk("s3_err_off", r_m0_err, 0);
        chk("s3_end_cyc", r_s_cyc, 0);

        // UART never acks: watchdog fires when the counter reaches 8
        tick(); req(1, 1, 32'h3000_8000);
        tick(); #1;
        chk("s4_cyc_0", r_s_cyc, 3'b100);
        for (int k = 1; k < 8; k++) begin
            tick(); #1;
            chk($sformatf("s4_cyc_%0d", k), r_s_cyc, 3'b100);
            chk($sformatf("s4_noerr_%0d", k), r_m1_err, 0);
        end
        tick(); #1;
        chk("s4_err", r_m1_err, 1);
        chk("s4_fx_err", f_m1_err, 1);
        chk("s4_cyc_drop", r_s_cyc, 0);
        chk("s4_noack", r_m1_ack, 0);
        tick(); req(1, 0, 0); #1;
        chk("s4_err_off", r_m1_err, 0);
        chk("s4_idle_cyc", r_s_cyc, 0);

        // ack arriving exactly on the watchdog limit
        tick(); req(0, 1, 32'h3000_0000);
        tick();
        repeat (7) tick();
        tick(); s_ack = 3'b001; #1;
        chk("s5_ack", r_m0_ack, 1);
        chk("s5_noerr", r_m0_err, 0);
        chk("s5_cyc", r_s_cyc, 3'b001);
        chk("s5_dat", r_m0_dat, 32'h1111_1111);
        tick(); req(0, 0, 0); s_ack = 0; #1;
        chk("s5_ack_off", r_m0_ack, 0);
        chk("s5_err_off", r_m0_err, 0);

        // reset pulse mid-transfer, then a normal transfer
        tick(); req(0, 1, 32'h3000_4000); m0_we = 1; m0_dat = 32'hCAFE_0001;
        tick(); #1;
        chk("s6_cyc", r_s_cyc, 3'b010);
        chk("s6_we", r_s_we, 1);
        chk("s6_wdat", r_s_dat, 32'hCAFE_0001);
        #2 rstn = 1'b0; #1;
        chk("s6_rst_cyc", r_s_cyc, 0);
        chk("s6_rst_stb", r_s_stb, 0);
        chk("s6_rst_adr", r_s_adr, 0);
        chk("s6_rst_wdat", r_s_dat, 0);
        chk("s6_rst_we", r_s_we, 0);
        chk("s6_rst_ack", r_m0_ack, 0);
        chk("s6_rst_err", r_m0_err, 0);
        req(0, 0, 0); m0_we = 0; m0_dat = 0;
        tick(); tick(); rstn = 1'b1; #1;
        chk("s6_rel_cyc", r_s_cyc, 0);
        chk("s6_rel_ack", r_m0_ack, 0);
        tick(); req(0, 1, 32'h3000_0000); #1;
        chk("s6_req_cyc", r_s_cyc, 0);
        tick(); #1;
        chk("s6_new_cyc", r_s_cyc, 3'b001);
        s_ack = 3'b001; #1;
        chk("s6_new_ack", r_m0_ack, 1);
        chk("s6_new_dat", r_m0_dat, 32'h1111_1111);
        tick(); req(0, 0, 0); s_ack = 0; #1;
        chk("s6_end_cyc", r_s_cyc, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
